encoder_8_3_arb: RTL
====================

Name: encoder_8_3_arb

Overview:
- Sequential 8-to-3 encoder. It is the return path for the 3-to-8 decode direction.
- Collects up to 8 request lines into a sticky pending register.
- Presents one pending index at a time as a 3-bit code with a valid/ack handshake.
- Sits between interrupt/request sources and a consumer that re-decodes or services the code.

Parameters:
- W, 3, code width; the number of request lines is N = 2**W (8).
- ACK_ERR_STICKY, 0; 1 = ack_err holds until reset, 0 = ack_err is a one-cycle pulse.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  enable; low withdraws any presented code and blocks new presentations
- req  input  N  request lines, level-sampled each clock; multi-hot allowed
- ack  input  1  consumer accepts the presented code
- code  output  W  encoded index of the presented request
- valid  output  1  code is valid
- pending  output  N  sticky pending register (observability)
- ack_err  output  1  ack received while valid=0

Behaviour:
- Reset (async, rst_n=0):
  - code=0, valid=0, pending=0, ack_err=0, state=IDLE.
  - Round-robin pointer last=N-1.
  - Applies immediately, including mid-HOLD.
- Pending register, per bit i, each edge:
  - Set if req[i]=1.
  - Else cleared if state=HOLD, ack=1 and code=i.
  - Simultaneous set and clear on the same bit: set wins.
  - Pending accumulates regardless of en.
- States: IDLE, HOLD.
- IDLE:
  - If en=1 and pending is nonzero: code<=select(pending), valid<=1, go to HOLD.
  - Otherwise valid=0.
  - Selection uses the registered pending, not the raw req.
- HOLD:
  - code and valid are stable until one of the events below.
  - en=0: valid<=0, go to IDLE. Pending is not cleared; the same code is re-presented once en returns, unless a higher-priority bit has arrived meanwhile.
  - en=1 and ack=1: clear the pending bit (rule above), valid<=0, last<=code, go to IDLE.
  - After ack there is always one IDLE bubble cycle with valid=0. Maximum throughput is one code per 2 cycles.
- Latency: req high at edge k → pending set at k → valid=1 after edge k+1.
- ack_err: set at an edge where ack=1 and valid=0. Behaviour is a pulse or sticky per ACK_ERR_STICKY. No other state change.
- Selection with the macro undefined: fixed priority, the highest index wins (7 > 6 > … > 0).
- A single-hot req round-trips through the 3-to-8 decoder to the same bit.

Optional Feature:
- Macro ENCODER_ROUND_ROBIN_EN.
- Defined: round-robin. The search starts at index (last+1) mod N and goes upward with wrap-around; the first pending bit found wins. After reset last=7, so the first search starts at index 0.
- Undefined: fixed highest-index priority. last is still maintained but unused.

Decomposition:
- Package enc_pkg:
  - Constants W=3, N=8.
  - State enum typedef {IDLE, HOLD}.
  - typedef for the code vector.
- Sub-module prio_sel_8_3: purely combinational.
  - Inputs: pending[N-1:0], start[W-1:0], rr mode.
  - Outputs: sel[W-1:0], any.
  - Fixed mode ignores start.

Test Plan:
- Reset: assert rst_n=0 mid-HOLD → code=0, valid=0, pending=0 asynchronously. After release, no valid until a new req.
- Single request: req=8'b0000_0100 pulsed 1 cycle, en=1 → valid=1 and code=2 after the second edge. ack=1 → next cycle valid=0, pending=0.
- Fixed priority: req=8'b1001_0010 pulsed, ack on every valid → codes 7, 4, 1 in order, each separated by one valid=0 bubble.
- Round-robin (macro defined): req=8'hFF held continuously, ack on every valid → codes 0, 1, 2, …, 7, 0. Pending stays 8'hFF.
- en drop: en=0 during HOLD on code 5 → valid=0 next cycle, pending[5] stays 1. en=1 → code 5 re-presented.
- Error and collision cases:
  - ack with valid=0 → ack_err=1 for one cycle (ACK_ERR_STICKY=0); pending and state unchanged.
  - ack on code 3 while req[3]=1 → pending[3] stays 1 and code 3 is re-presented after the bubble.

Source files
------------

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants and types for the 8-to-3 arbitrating encoder
// Purpose: code width / request count constants, FSM state enum, code vector type.
// Ports: none (package).
package enc_pkg;

  localparam int W = 3;
  localparam int N = 1 << W;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [W-1:0] code_t;

endpackage

// File: rtl/prio_sel_8_3.sv
// rtl/prio_sel_8_3.sv - combinational pending-bit selector (fixed or round-robin)
// Purpose: pick one set bit of i_pending.
//   fixed mode (i_rr=0): highest set index wins, i_start ignored.
//   round-robin (i_rr=1): first set bit found searching upward from i_start, wrapping.
// Ports:
//   i_pending [N-1:0] candidate bits
//   i_start   [W-1:0] round-robin search origin
//   i_rr              1 = round-robin, 0 = fixed priority
//   o_sel     [W-1:0] selected index (0 when nothing is set)
//   o_any             at least one bit of i_pending is set
module prio_sel_8_3 #(
  parameter int W = enc_pkg::W
) (
  input  logic [(1<<W)-1:0] i_pending,
  input  logic [W-1:0]      i_start,
  input  logic              i_rr,
  output logic [W-1:0]      o_sel,
  output logic              o_any
);

  localparam int N = 1 << W;

  logic [W-1:0] w_idx;
  logic         w_found;

  always_comb begin
    o_sel   = '0;
    o_any   = |i_pending;
    w_idx   = '0;
    w_found = 1'b0;
    if (i_rr) begin
      // Offset arithmetic is W bits wide, so the index wraps modulo N for free.
      for (int k = 0; k < N; k++) begin
        w_idx = i_start + k[W-1:0];
        if (!w_found && i_pending[w_idx]) begin
          o_sel   = w_idx;
          w_found = 1'b1;
        end
      end
    end else begin
      // Ascending scan: the last hit is the highest index.
      for (int k = 0; k < N; k++) begin
        if (i_pending[k]) o_sel = k[W-1:0];
      end
    end
  end

endmodule

// File: rtl/encoder_8_3_arb.sv
// rtl/encoder_8_3_arb.sv - sequential 8-to-3 encoder with sticky pending and valid/ack
// Purpose: latch request lines into a sticky pending register and present one
//   pending index at a time as a code with a valid/ack handshake.
// Build option: define ENCODER_ROUND_ROBIN_EN for round-robin selection,
//   otherwise fixed priority (highest index wins).
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       enable; low withdraws the presented code and blocks new ones
//   req      [N-1:0] level-sampled request lines (multi-hot allowed)
//   ack      consumer accepts the presented code
//   code     [W-1:0] presented index
//   valid    code is valid
//   pending  [N-1:0] sticky pending register
//   ack_err  ack seen while valid=0 (pulse, or sticky when ACK_ERR_STICKY=1)
module encoder_8_3_arb #(
  parameter int W              = 3,
  parameter bit ACK_ERR_STICKY = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [(1<<W)-1:0]   req,
  input  logic                ack,
  output logic [W-1:0]        code,
  output logic                valid,
  output logic [(1<<W)-1:0]   pending,
  output logic                ack_err
);

  import enc_pkg::*;

  localparam int NR = 1 << W;

`ifdef ENCODER_ROUND_ROBIN_EN
  localparam logic RR_MODE = 1'b1;
`else
  localparam logic RR_MODE = 1'b0;
`endif

  state_t          r_state;
  logic [W-1:0]    r_code;
  logic            r_valid;
  logic [NR-1:0]   r_pending;
  logic            r_ack_err;
  logic [W-1:0]    r_last;

  logic [W-1:0]    w_start;
  logic [W-1:0]    w_sel;
  logic            w_any;
  logic            w_accept;
  logic [NR-1:0]   w_clr_mask;
  logic [NR-1:0]   w_pending_nxt;

  assign w_start  = r_last + {{(W-1){1'b0}}, 1'b1};
  assign w_accept = (r_state == HOLD) && en && ack;

  always_comb begin
    w_clr_mask = '0;
    if (w_accept) w_clr_mask[r_code] = 1'b1;
  end

  // Set is applied after clear so a request on the acked bit keeps it pending.
  assign w_pending_nxt = (r_pending & ~w_clr_mask) | req;

  prio_sel_8_3 #(.W(W)) u_sel (
    .i_pending (r_pending),
    .i_start   (w_start),
    .i_rr      (RR_MODE),
    .o_sel     (w_sel),
    .o_any     (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_pending <= '0;
      r_ack_err <= 1'b0;
      r_last    <= '1;
    end else begin
      r_pending <= w_pending_nxt;

      if (ACK_ERR_STICKY) begin
        if (ack && !r_valid) r_ack_err <= 1'b1;
      end else begin
        r_ack_err <= ack && !r_valid;
      end

      case (r_state)
        IDLE: begin
          if (en && w_any) begin
            r_code  <= w_sel;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!en) begin
            // Withdraw only; the pending bit survives for re-presentation.
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (ack) begin
            r_valid <= 1'b0;
            r_last  <= r_code;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign code    = r_code;
  assign valid   = r_valid;
  assign pending = r_pending;
  assign ack_err = r_ack_err;

endmodule
